mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle multiply/divide sequencer for the 16-bit processor. It reuses the shared combinational ALU's add and subtract operations, one iteration per clock, to compute 16×16→32 unsigned products and 16÷16 unsigned quotient/remainder into HI/LO. It sits beside the execute stage: the stage issues `start`, stalls on `busy`, and the parent instantiates the ALU and routes its operand and control ports to this block while `busy` is high.

## Interface
- No parameters. Width is fixed at 16 and the iteration count at 16.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; accepted only when the block is in IDLE
- `op`  in  1  0 = MUL, 1 = DIV; sampled with `start`
- `opa`  in  16  multiplicand or dividend; sampled with `start`
- `opb`  in  16  multiplier or divisor; sampled with `start`
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward
- `hi`  out  16  product[31:16] or remainder
- `lo`  out  16  product[15:0] or quotient
- `dbz`  out  1  divide-by-zero flag; updated on every accepted `start`
- `alu_a`, `alu_b`  out  16  ALU operands
- `alu_c`  out  3  ALU control
- `alu_out`  in  16  ALU result
- `alu_zero`  in  1  ALU zero flag
- `alu_ag`  in  1  ALU unsigned A>B flag

## Operation
**States**
- IDLE: `alu_c` = 111 (ALU outputs zero).
- RUN
- Reset value of every output is 0. Exception: `alu_c` resets to 111.

**Accept (IDLE, `start`=1)**
- Latch `op`, `opa` and `opb` into internal operand registers.
- Clear the 4-bit iteration counter.
- Set `dbz`=0.
- Go to RUN.
- `start` outside IDLE is ignored. It is not queued.

**Divide by zero** (`op`=DIV and `opb`=0 at accept)
- Do not enter RUN.
- Set `hi`=`opa`, `lo`=16'hFFFF, `dbz`=1.
- Pulse `done` on the next cycle and stay in IDLE.

**MUL step** (P = {hi, lo}, with `lo` initialised to `opb` and `hi` to 0)
- `alu_a`=`hi`, `alu_b`=multiplicand.
- `alu_c` = 000 if `lo[0]` is 1, otherwise 111.
- sum = `lo[0]` ? `alu_out` : `hi`.
- carry = `lo[0]` & (a15&b15 | (a15|b15)&~sum15). Carry is computed locally because the ALU provides no carry-out.
- Update: {hi, lo} ← {carry, sum, lo[15:1]}.

**DIV step** (R in `hi`, initialised to 0; Q in `lo`, initialised to `opa`)
- Rs = {hi[14:0], lo[15]}. Rs always fits in 16 bits, because R < 2^k after k steps.
- `alu_a`=Rs, `alu_b`=divisor, `alu_c`=001.
- If `alu_ag` | `alu_zero` (that is, Rs ≥ D): hi ← `alu_out`, lo ← {lo[14:0],1}.
- Otherwise: hi ← Rs, lo ← {lo[14:0],0}.

**Results and reset**
- After 16 steps, `hi`/`lo` hold the result. They hold until the next accept, which re-initialises them.
- `rst` mid-operation returns the block to IDLE, clears all outputs and discards the operation.

## Timing
- Edge 0: `start` is sampled with `busy`=0, and the operands are loaded. From edge 0 to edge 16, `busy`=1 and the ALU ports carry step operands.
- Edges 1–16: one step per edge. The ALU is combinational, and `alu_out`/flags are consumed in the same cycle the operands are driven.
- Edge 16: the last step is registered and the state returns to IDLE. In the cycle after edge 16, `done`=1, `busy`=0 and results are valid.
- Edge 17: `done` returns to 0. A `start` held at edge 16 is ignored, because `busy` was high. A `start` at edge 17 is accepted. Back-to-back throughput is 17 cycles.
- Divide by zero: the result is visible and `done`=1 in the cycle after edge 0, and `busy` never asserts.
- `alu_*` outputs are combinational from state and registers. The parent must not rely on ALU results while `busy`=1.

## Structure
- Package `mdu_pkg` holds:
  - ALU control constants: ALU_ADD=000, ALU_SUB=001, ALU_ZERO=111.
  - Operation constants: OP_MUL=0, OP_DIV=1.
  - State encoding: IDLE, RUN.
- Single module with no sub-module. The ALU is instantiated by the parent, and the bench instantiates the real ALU alongside this block.

## Test plan
- MUL 0x1234 × 0x5678 → `done` exactly 17 cycles after `start`, `hi`=0x0626, `lo`=0x0060, `dbz`=0.
- MUL 0xFFFF × 0xFFFF → `hi`=0xFFFE, `lo`=0x0001. This exercises the carry on every step.
- DIV 0x03E8 ÷ 0x0007 → `lo`=0x008E, `hi`=0x0006. Also DIV 0xFFFF ÷ 0xFFFF → `lo`=1, `hi`=0, which exercises the equal case via `alu_zero`.
- DIV 0x1234 ÷ 0 → `done` one cycle after `start`, `busy` never high, `dbz`=1, `hi`=0x1234, `lo`=0xFFFF.
- Hold `start` high continuously with alternating operands → the second request is accepted at edge 17 and nothing is accepted during `busy`. Then assert `rst` at step 8 of a MUL → all outputs go to 0, `alu_c`=111, and the next `start` completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencer.
package mdu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_ZERO = 3'b111;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/result bus and borrowed-ALU port bundle between the execute stage and the sequencer.
interface mdu_sequencer_if;
    logic        start;
    logic        op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        busy;
    logic        done;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_c;
    logic [15:0] alu_out;
    logic        alu_zero;
    logic        alu_ag;

    // Parent side: issues requests and returns the shared ALU's results.
    modport master (
        output start, op, opa, opb, alu_out, alu_zero, alu_ag,
        input  busy, done, hi, lo, dbz, alu_a, alu_b, alu_c
    );

    modport slave (
        input  start, op, opa, opb, alu_out, alu_zero, alu_ag,
        output busy, done, hi, lo, dbz, alu_a, alu_b, alu_c
    );
endinterface

// File: rtl/mdu_sequencer.sv
// 16-step shift-add multiplier / restoring divider that borrows the shared ALU,
// one iteration per clock, with results left in HI/LO.
module mdu_sequencer
    import mdu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mdu_sequencer_if.slave bus
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic [15:0] rem_shift;
    logic [15:0] mul_sum;
    logic        mul_carry;
    logic        div_ge;
    logic [15:0] alu_a_c;
    logic [15:0] alu_b_c;
    logic [2:0]  alu_c_c;

    // Datapath helpers and ALU operand steering.
    always_comb begin
        rem_shift = {hi_q[14:0], lo_q[15]};
        mul_sum   = lo_q[0] ? bus.alu_out : hi_q;
        // The ALU has no carry-out, so recover it from the operand and sum MSBs.
        mul_carry = lo_q[0] & ((hi_q[15] & opa_q[15]) |
                               ((hi_q[15] | opa_q[15]) & ~mul_sum[15]));
        div_ge    = bus.alu_ag | bus.alu_zero;

        alu_a_c = 16'h0000;
        alu_b_c = 16'h0000;
        alu_c_c = ALU_ZERO;
        if (state_q == RUN) begin
            if (op_q == OP_MUL) begin
                alu_a_c = hi_q;
                alu_b_c = opa_q;
                alu_c_c = lo_q[0] ? ALU_ADD : ALU_ZERO;
            end else begin
                alu_a_c = rem_shift;
                alu_b_c = opb_q;
                alu_c_c = ALU_SUB;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    opa_d = bus.opa;
                    opb_d = bus.opb;
                    cnt_d = 4'd0;
                    dbz_d = 1'b0;
                    if ((bus.op == OP_DIV) && (bus.opb == 16'h0000)) begin
                        hi_d   = bus.opa;
                        lo_d   = 16'hFFFF;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        hi_d    = 16'h0000;
                        lo_d    = (bus.op == OP_MUL) ? bus.opb : bus.opa;
                    end
                end
            end
            RUN: begin
                if (op_q == OP_MUL) begin
                    {hi_d, lo_d} = {mul_carry, mul_sum, lo_q[15:1]};
                end else begin
                    hi_d = div_ge ? bus.alu_out : rem_shift;
                    lo_d = {lo_q[14:0], div_ge};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_MUL;
            opa_q   <= 16'h0000;
            opb_q   <= 16'h0000;
            hi_q    <= 16'h0000;
            lo_q    <= 16'h0000;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.dbz   = dbz_q;
    assign bus.alu_a = alu_a_c;
    assign bus.alu_b = alu_b_c;
    assign bus.alu_c = alu_c_c;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed vector table, back-to-back/reset sequences,
// and random operations checked against plain integer arithmetic.
module tb_mdu_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mdu_sequencer_if bus ();

    mdu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared combinational ALU as the parent would provide it.
    always_comb begin
        case (bus.alu_c)
            3'b000:  bus.alu_out = bus.alu_a + bus.alu_b;
            3'b001:  bus.alu_out = bus.alu_a - bus.alu_b;
            default: bus.alu_out = 16'h0000;
        endcase
        bus.alu_zero = (bus.alu_out == 16'h0000);
        bus.alu_ag   = (bus.alu_a > bus.alu_b);
    end

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eh;
        logic [15:0] el;
        logic        ed;
        int          elat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {dbz, hi, lo} from unsigned integer arithmetic.
    function automatic logic [32:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        if (op == 1'b0) begin
            p = {16'h0, a} * {16'h0, b};
            return {1'b0, p};
        end
        if (b == 16'h0000) return {1'b1, a, 16'hFFFF};
        return {1'b0, a % b, a / b};
    endfunction

    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] h, output logic [15:0] l, output logic d,
                          output int lat, output logic saw_busy, output logic got_done,
                          output logic pulse_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat       = 1;
        saw_busy  = bus.busy;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            saw_busy = saw_busy | bus.busy;
        end
        got_done = bus.done;
        h        = bus.hi;
        l        = bus.lo;
        d        = bus.dbz;
        @(posedge clk);
        #1;
        pulse_ok = !bus.done;
        $display("op=%0d a=0x%04h b=0x%04h -> hi=0x%04h lo=0x%04h dbz=%0d lat=%0d",
                 op, a, b, h, l, d, lat);
    endtask

    initial begin
        logic [15:0] h, l;
        logic        d, sb, gd, pk, early;
        logic        rop;
        logic [15:0] ra, rb;
        logic [32:0] exp;
        int          lat;

        checks = 0;
        errors = 0;

        vecs[0] = '{1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 17};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17};
        vecs[2] = '{1'b1, 16'h03E8, 16'h0007, 16'h0006, 16'h008E, 1'b0, 17};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 17};
        vecs[4] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.opa   = 16'h0000;
        bus.opb   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_hi", {16'b0, bus.hi}, 32'd0);
        chk("reset_lo", {16'b0, bus.lo}, 32'd0);
        chk("reset_dbz", {31'b0, bus.dbz}, 32'd0);
        chk("reset_alu_c", {29'b0, bus.alu_c}, 32'd7);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, h, l, d, lat, sb, gd, pk);
            chk($sformatf("vec%0d_done_seen", i), {31'b0, gd}, 32'd1);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].elat);
            chk($sformatf("vec%0d_hi", i), {16'b0, h}, {16'b0, vecs[i].eh});
            chk($sformatf("vec%0d_lo", i), {16'b0, l}, {16'b0, vecs[i].el});
            chk($sformatf("vec%0d_dbz", i), {31'b0, d}, {31'b0, vecs[i].ed});
            chk($sformatf("vec%0d_busy_seen", i), {31'b0, sb}, {31'b0, ~vecs[i].ed});
            chk($sformatf("vec%0d_done_pulse", i), {31'b0, pk}, 32'd1);
        end

        // start held high: the request presented during busy must wait for edge 17.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.opa   = 16'h1234;
        bus.opb   = 16'h5678;
        @(posedge clk);
        #1;
        bus.op  = 1'b1;
        bus.opa = 16'h03E8;
        bus.opb = 16'h0007;
        early   = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            if (e < 16) early = early | bus.done | ~bus.busy;
        end
        chk("b2b_no_early_done", {31'b0, early}, 32'd0);
        chk("b2b_first_done", {31'b0, bus.done}, 32'd1);
        chk("b2b_first_busy", {31'b0, bus.busy}, 32'd0);
        chk("b2b_first_result", {bus.hi, bus.lo}, 32'h06260060);
        $display("b2b first: hi=0x%04h lo=0x%04h", bus.hi, bus.lo);
        @(posedge clk);
        #1;
        chk("b2b_accept_edge17", {31'b0, bus.busy}, 32'd1);
        chk("b2b_done_cleared", {31'b0, bus.done}, 32'd0);
        bus.start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("b2b_second_done", {31'b0, bus.done}, 32'd1);
        chk("b2b_second_result", {bus.hi, bus.lo}, 32'h0006008E);
        $display("b2b second: hi=0x%04h lo=0x%04h", bus.hi, bus.lo);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.opa   = 16'hFFFF;
        bus.opb   = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_mid_done", {31'b0, bus.done}, 32'd0);
        chk("rst_mid_hilo", {bus.hi, bus.lo}, 32'd0);
        chk("rst_mid_dbz", {31'b0, bus.dbz}, 32'd0);
        chk("rst_mid_alu_c", {29'b0, bus.alu_c}, 32'd7);
        chk("rst_mid_alu_ab", {bus.alu_a, bus.alu_b}, 32'd0);
        $display("reset mid-mul applied");
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 16'h1234, 16'h5678, h, l, d, lat, sb, gd, pk);
        chk("post_rst_latency", lat, 17);
        chk("post_rst_result", {h, l}, 32'h06260060);

        for (int i = 0; i < 60; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            exp = model(rop, ra, rb);
            run_op(rop, ra, rb, h, l, d, lat, sb, gd, pk);
            chk($sformatf("rnd%0d_result", i), {h, l}, exp[31:0]);
            chk($sformatf("rnd%0d_dbz", i), {31'b0, d}, {31'b0, exp[32]});
            chk($sformatf("rnd%0d_latency", i), lat, exp[32] ? 1 : 17);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
